// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB initiator.
// Converts local-bus requests into APB SETUP/ACCESS transfers. It returns one
// registered response per request, and it aborts with an error when a
// responder holds pready low for too long.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STRB_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // This is the last ACCESS cycle count before the abort. It is only
    // meaningful when the timeout is enabled.
    localparam logic [TO_W-1:0] TIMEOUT_LAST_C =
        (TIMEOUT_CYCLES == 0) ? {TO_W{1'b0}} : TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN_C = (TIMEOUT_CYCLES != 0);

    state_t          state_r;
    logic [TO_W-1:0] timeout_cnt_r;
    logic            timeout_hit_s;

    // A request is accepted only while idle; the transfer is one-outstanding.
    assign req_ready = (state_r == ST_IDLE);

    // Abort condition: the responder is still stalling in the last permitted ACCESS cycle.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT_EN_C && (timeout_cnt_r == TIMEOUT_LAST_C)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer FSM with registered APB outputs and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            timeout_cnt_r <= {TO_W{1'b0}};
            psel          <= 1'b0;
            penable       <= 1'b0;
            pwrite        <= 1'b0;
            paddr         <= {ADDR_W{1'b0}};
            pwdata        <= {DATA_W{1'b0}};
            pstrb         <= {STRB_W{1'b0}};
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= {DATA_W{1'b0}};
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    penable <= 1'b0;
                    if (req_valid) begin
                        // Reads carry no write payload on the bus.
                        psel    <= 1'b1;
                        paddr   <= req_addr;
                        pwrite  <= req_write;
                        pwdata  <= req_write ? req_wdata : {DATA_W{1'b0}};
                        pstrb   <= req_write ? req_wstrb : {STRB_W{1'b0}};
                        state_r <= ST_SETUP;
                    end else begin
                        psel    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    psel          <= 1'b1;
                    penable       <= 1'b1;
                    timeout_cnt_r <= {TO_W{1'b0}};
                    state_r       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= pslverr;
                        resp_rdata <= (!pwrite && !pslverr) ? prdata : {DATA_W{1'b0}};
                        state_r    <= ST_IDLE;
                    end else if (timeout_hit_s) begin
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= {DATA_W{1'b0}};
                        state_r    <= ST_IDLE;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge. A scoreboard queue holds the
// expected responses, and a protocol monitor checks that the address and
// direction stay stable while psel is held high.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = 32'h0;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic        prev_psel = 1'b0;
    logic [31:0] prev_paddr = 32'h0;
    logic        prev_pwrite = 1'b0;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(4), .TO_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                chk("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    // Protocol monitor: paddr/pwrite are stable while psel stays asserted.
    always @(negedge clk) begin
        if (psel === 1'b1 && prev_psel === 1'b1) begin
            chk("paddr_stable", 64'(paddr), 64'(prev_paddr));
            chk("pwrite_stable", 64'(pwrite), 64'(prev_pwrite));
        end
        prev_psel   = psel;
        prev_paddr  = paddr;
        prev_pwrite = pwrite;
    end

    initial begin
        // ---- reset state ----
        step(); step(); step();
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // ---- zero-wait write ----
        pready = 1'b1; pslverr = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8;
        req_wdata = 32'h5A; req_wstrb = 4'h1;
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        step(); // SETUP
        req_valid = 1'b0;
        chk("w_setup_psel", 64'(psel), 64'd1);
        chk("w_setup_penable", 64'(penable), 64'd0);
        chk("w_setup_ready", 64'(req_ready), 64'd0);
        chk("w_paddr", 64'(paddr), 64'h8);
        chk("w_pwdata", 64'(pwdata), 64'h5A);
        chk("w_pstrb", 64'(pstrb), 64'h1);
        chk("w_pwrite", 64'(pwrite), 64'd1);
        step(); // ACCESS
        chk("w_access_penable", 64'(penable), 64'd1);
        chk("w_access_rv", 64'(resp_valid), 64'd0);
        step(); // response
        chk("w_resp_valid", 64'(resp_valid), 64'd1);
        chk("w_resp_psel", 64'(psel), 64'd0);
        step();
        chk("w_resp_one_cycle", 64'(resp_valid), 64'd0);

        // ---- one-wait read ----
        pready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4;
        req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        sb_q.push_back('{rdata: 32'h3, err: 1'b0});
        step(); // SETUP
        req_valid = 1'b0;
        chk("r_pstrb", 64'(pstrb), 64'd0);
        chk("r_pwdata", 64'(pwdata), 64'd0);
        chk("r_pwrite", 64'(pwrite), 64'd0);
        step(); // ACCESS 1 (wait)
        chk("r_acc1_penable", 64'(penable), 64'd1);
        step(); // ACCESS 2
        chk("r_acc2_penable", 64'(penable), 64'd1);
        chk("r_acc2_rv", 64'(resp_valid), 64'd0);
        pready = 1'b1; prdata = 32'h3;
        step();
        chk("r_resp_valid", 64'(resp_valid), 64'd1);
        chk("r_resp_penable", 64'(penable), 64'd0);
        prdata = 32'h0;

        // ---- slave error on write (prdata ignored) ----
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
        req_wdata = 32'h1; req_wstrb = 4'hF;
        pslverr = 1'b1; prdata = 32'hDEAD;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        step(); req_valid = 1'b0;
        step();
        step();
        chk("e_resp_valid", 64'(resp_valid), 64'd1);
        chk("e_req_ready", 64'(req_ready), 64'd1);
        chk("e_psel", 64'(psel), 64'd0);
        pslverr = 1'b0;
        step();
        chk("e_err_hold", 64'(resp_err), 64'd1);

        // ---- read with slave error: data forced to zero ----
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h14;
        pslverr = 1'b1; prdata = 32'h77;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        step(); req_valid = 1'b0;
        step(); step();
        chk("re_resp_valid", 64'(resp_valid), 64'd1);
        pslverr = 1'b0;

        // ---- timeout: pready stuck low ----
        pready = 1'b0; prdata = 32'h99;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        step(); req_valid = 1'b0; // SETUP
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t_access_penable", 64'(penable), 64'd1);
            chk("t_access_rv", 64'(resp_valid), 64'd0);
        end
        step();
        chk("t_psel", 64'(psel), 64'd0);
        chk("t_penable", 64'(penable), 64'd0);
        chk("t_resp_valid", 64'(resp_valid), 64'd1);

        // ---- back-to-back: read 0xC then write 0x0 ----
        pready = 1'b1; prdata = 32'h12;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hC;
        sb_q.push_back('{rdata: 32'h12, err: 1'b0});
        step(); // SETUP of read; present the next request
        req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hAB; req_wstrb = 4'h3;
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        step(); // ACCESS of read
        chk("b_paddr_read", 64'(paddr), 64'hC);
        step(); // response of read; second request accepted here
        chk("b_resp1_valid", 64'(resp_valid), 64'd1);
        chk("b_resp1_ready", 64'(req_ready), 64'd1);
        step(); // SETUP of write
        req_valid = 1'b0;
        chk("b_psel2", 64'(psel), 64'd1);
        chk("b_paddr2", 64'(paddr), 64'h0);
        chk("b_pwrite2", 64'(pwrite), 64'd1);
        chk("b_pwdata2", 64'(pwdata), 64'hAB);
        step(); // ACCESS
        step(); // response
        chk("b_resp2_valid", 64'(resp_valid), 64'd1);

        // ---- reset in ACCESS: no response ----
        pready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        step(); req_valid = 1'b0; // SETUP
        step(); // ACCESS
        chk("x_penable_before", 64'(penable), 64'd1);
        rst = 1'b1;
        pready = 1'b1;
        step();
        chk("x_psel", 64'(psel), 64'd0);
        chk("x_penable", 64'(penable), 64'd0);
        chk("x_paddr", 64'(paddr), 64'd0);
        chk("x_resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        step();
        chk("x_req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("x_no_resp", 64'(resp_valid), 64'd0);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
